// File: rtl/axil_cmd_master.sv
// axil_cmd_master: turns single-word register commands into AXI4-Lite
// read/write transactions. One transaction in flight at a time. A saturating
// per-command wait counter forces a response if the slave never finishes.
module axil_cmd_master #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        axilClk,
    input  logic        axilRstN,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_wstrb,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_resp,
    output logic        rsp_timeout,
    output logic [31:0] axilWriteMaster_awaddr,
    output logic [2:0]  axilWriteMaster_awprot,
    output logic        axilWriteMaster_awvalid,
    input  logic        axilWriteSlave_awready,
    output logic [31:0] axilWriteMaster_wdata,
    output logic [3:0]  axilWriteMaster_wstrb,
    output logic        axilWriteMaster_wvalid,
    input  logic        axilWriteSlave_wready,
    input  logic [1:0]  axilWriteSlave_bresp,
    input  logic        axilWriteSlave_bvalid,
    output logic        axilWriteMaster_bready,
    output logic [31:0] axilReadMaster_araddr,
    output logic [2:0]  axilReadMaster_arprot,
    output logic        axilReadMaster_arvalid,
    input  logic        axilReadSlave_arready,
    input  logic [31:0] axilReadSlave_rdata,
    input  logic [1:0]  axilReadSlave_rresp,
    input  logic        axilReadSlave_rvalid,
    output logic        axilReadMaster_rready
);

    typedef enum logic [2:0] {IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RESP} state_t;

    localparam logic [15:0] TMO = 16'(TIMEOUT_CYCLES);

    state_t      state_q;
    logic [15:0] tmo_cnt_q, tmo_cnt_d;
    logic        cmd_ready_q;
    logic        awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  wstrb_q;
    logic        rsp_valid_q, rsp_timeout_q;
    logic [31:0] rsp_rdata_q;
    logic [1:0]  rsp_resp_q;

    logic aw_done, w_done, progress, abort;

    // A channel counts as done once its valid is gone or its ready is sampled now.
    assign aw_done = !awvalid_q || axilWriteSlave_awready;
    assign w_done  = !wvalid_q  || axilWriteSlave_wready;

    // Saturating wait counter; the limit is hit at the edge that would make it TMO.
    assign tmo_cnt_d = (tmo_cnt_q == 16'hFFFF) ? tmo_cnt_q : tmo_cnt_q + 16'd1;

    // A state that advances this cycle beats the timeout decided in the same cycle.
    always_comb begin
        progress = 1'b1;
        case (state_q)
            WR_AW_W: progress = aw_done && w_done;
            WR_B:    progress = axilWriteSlave_bvalid;
            RD_AR:   progress = axilReadSlave_arready;
            RD_R:    progress = axilReadSlave_rvalid;
            default: progress = 1'b1;
        endcase
    end

    assign abort = (tmo_cnt_d >= TMO) && !progress;

    // Command FSM with all bus and response outputs registered.
    always_ff @(posedge axilClk or negedge axilRstN) begin
        if (!axilRstN) begin
            state_q       <= IDLE;
            tmo_cnt_q     <= '0;
            cmd_ready_q   <= 1'b0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            bready_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            rready_q      <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            if (state_q != IDLE && state_q != RESP)
                tmo_cnt_q <= tmo_cnt_d;
            if (abort) begin
                awvalid_q     <= 1'b0;
                wvalid_q      <= 1'b0;
                bready_q      <= 1'b0;
                arvalid_q     <= 1'b0;
                rready_q      <= 1'b0;
                rsp_valid_q   <= 1'b1;
                rsp_timeout_q <= 1'b1;
                rsp_resp_q    <= 2'b11;
                rsp_rdata_q   <= '0;
                state_q       <= RESP;
            end else begin
                case (state_q)
                    IDLE: begin
                        cmd_ready_q <= 1'b1;
                        if (cmd_valid && cmd_ready_q) begin
                            cmd_ready_q <= 1'b0;
                            addr_q      <= cmd_addr;
                            wdata_q     <= cmd_wdata;
                            wstrb_q     <= cmd_wstrb;
                            tmo_cnt_q   <= '0;
                            if (cmd_write) begin
                                awvalid_q <= 1'b1;
                                wvalid_q  <= 1'b1;
                                state_q   <= WR_AW_W;
                            end else begin
                                arvalid_q <= 1'b1;
                                state_q   <= RD_AR;
                            end
                        end
                    end
                    WR_AW_W: begin
                        if (axilWriteSlave_awready) awvalid_q <= 1'b0;
                        if (axilWriteSlave_wready)  wvalid_q  <= 1'b0;
                        if (aw_done && w_done) begin
                            bready_q <= 1'b1;
                            state_q  <= WR_B;
                        end
                    end
                    WR_B: begin
                        if (axilWriteSlave_bvalid) begin
                            bready_q      <= 1'b0;
                            rsp_valid_q   <= 1'b1;
                            rsp_timeout_q <= 1'b0;
                            rsp_resp_q    <= axilWriteSlave_bresp;
                            rsp_rdata_q   <= '0;
                            state_q       <= RESP;
                        end
                    end
                    RD_AR: begin
                        if (axilReadSlave_arready) begin
                            arvalid_q <= 1'b0;
                            rready_q  <= 1'b1;
                            state_q   <= RD_R;
                        end
                    end
                    RD_R: begin
                        if (axilReadSlave_rvalid) begin
                            rready_q      <= 1'b0;
                            rsp_valid_q   <= 1'b1;
                            rsp_timeout_q <= 1'b0;
                            rsp_resp_q    <= axilReadSlave_rresp;
                            rsp_rdata_q   <= axilReadSlave_rdata;
                            state_q       <= RESP;
                        end
                    end
                    RESP: begin
                        cmd_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign cmd_ready               = cmd_ready_q;
    assign rsp_valid               = rsp_valid_q;
    assign rsp_rdata               = rsp_rdata_q;
    assign rsp_resp                = rsp_resp_q;
    assign rsp_timeout             = rsp_timeout_q;
    assign axilWriteMaster_awaddr  = addr_q;
    assign axilWriteMaster_awprot  = 3'b000;
    assign axilWriteMaster_awvalid = awvalid_q;
    assign axilWriteMaster_wdata   = wdata_q;
    assign axilWriteMaster_wstrb   = wstrb_q;
    assign axilWriteMaster_wvalid  = wvalid_q;
    assign axilWriteMaster_bready  = bready_q;
    assign axilReadMaster_araddr   = addr_q;
    assign axilReadMaster_arprot   = 3'b000;
    assign axilReadMaster_arvalid  = arvalid_q;
    assign axilReadMaster_rready   = rready_q;

endmodule

// File: tb/tb_axil_cmd_master.sv
// Bench for axil_cmd_master: directed timing cases plus random commands
// against a programmable-delay AXI-Lite slave and a word-memory model.
module tb_axil_cmd_master;

    localparam int TMO = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;

    axil_cmd_master #(.TIMEOUT_CYCLES(TMO)) dut (
        .axilClk(clk), .axilRstN(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .rsp_timeout(rsp_timeout),
        .axilWriteMaster_awaddr(awaddr), .axilWriteMaster_awprot(awprot),
        .axilWriteMaster_awvalid(awvalid), .axilWriteSlave_awready(awready),
        .axilWriteMaster_wdata(wdata), .axilWriteMaster_wstrb(wstrb),
        .axilWriteMaster_wvalid(wvalid), .axilWriteSlave_wready(wready),
        .axilWriteSlave_bresp(bresp), .axilWriteSlave_bvalid(bvalid),
        .axilWriteMaster_bready(bready),
        .axilReadMaster_araddr(araddr), .axilReadMaster_arprot(arprot),
        .axilReadMaster_arvalid(arvalid), .axilReadSlave_arready(arready),
        .axilReadSlave_rdata(rdata), .axilReadSlave_rresp(rresp),
        .axilReadSlave_rvalid(rvalid), .axilReadMaster_rready(rready)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  resp;
        logic        tmo;
        int          c0;
        int          lat;
    } exp_t;
    exp_t sb[$];

    // Reference memory (driver side) and slave memory (bus side).
    logic [31:0] rmem [logic [31:0]];
    logic [31:0] smem [logic [31:0]];

    // Per-command slave behaviour and expected bus values.
    int aw_dly, w_dly, b_dly, ar_dly, r_dly;
    bit stall;
    logic [31:0] x_addr, x_wdata;
    logic [3:0]  x_wstrb;

    // Slave: each ready/valid fires after its programmed number of wait cycles.
    bit aw_got, w_got, ar_got;
    int aw_c, w_c, b_c, ar_c, r_c;
    logic [31:0] sa, sd;
    logic [3:0]  ss;
    initial begin
        {awready, wready, bvalid, arready, rvalid} = '0;
        bresp = '0; rresp = '0; rdata = '0;
        forever begin
            @(posedge clk); #1;
            {awready, wready, bvalid, arready, rvalid} = '0;
            if (!rst_n || cmd_ready) begin
                {aw_got, w_got, ar_got} = '0;
                {aw_c, w_c, b_c, ar_c, r_c} = '0;
            end else if (!stall) begin
                if (aw_got) check("awvalid_drop", 32'(awvalid), 0);
                if (w_got)  check("wvalid_drop", 32'(wvalid), 0);
                if (ar_got) check("arvalid_drop", 32'(arvalid), 0);
                if (awvalid && !aw_got) begin
                    if (aw_c == aw_dly) begin
                        awready = 1'b1; aw_got = 1'b1; sa = awaddr;
                        check("awaddr", awaddr, x_addr);
                    end else aw_c++;
                end
                if (wvalid && !w_got) begin
                    if (w_c == w_dly) begin
                        wready = 1'b1; w_got = 1'b1; sd = wdata; ss = wstrb;
                        check("wdata", wdata, x_wdata);
                        check("wstrb", 32'(wstrb), 32'(x_wstrb));
                    end else w_c++;
                end
                if (bready) begin
                    check("bready_order", 32'({aw_got, w_got}), 32'd3);
                    if (b_c == b_dly) begin
                        bvalid = 1'b1; bresp = sa[5:4];
                        smem[sa] = merge(smem.exists(sa) ? smem[sa] : 32'h0, sd, ss);
                    end else b_c++;
                end
                if (arvalid && !ar_got) begin
                    if (ar_c == ar_dly) begin
                        arready = 1'b1; ar_got = 1'b1; sa = araddr;
                        check("araddr", araddr, x_addr);
                    end else ar_c++;
                end
                if (rready) begin
                    if (r_c == r_dly) begin
                        rvalid = 1'b1; rresp = sa[5:4];
                        rdata = smem.exists(sa) ? smem[sa] : 32'h0;
                    end else r_c++;
                end
            end
        end
    end

    // Monitor: every response pulse is matched against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk); #1;
            if (rst_n && rsp_valid) begin
                if (sb.size() == 0) check("unexpected_rsp", 32'(rsp_valid), 0);
                else begin
                    e = sb.pop_front();
                    check("rsp_rdata", rsp_rdata, e.rdata);
                    check("rsp_resp", 32'(rsp_resp), 32'(e.resp));
                    check("rsp_timeout", 32'(rsp_timeout), 32'(e.tmo));
                    check("rsp_latency", 32'(cyc - e.c0), 32'(e.lat));
                    check("bus_idle_at_rsp", 32'({awvalid, wvalid, bready, arvalid, rready}), 0);
                end
            end
        end
    end

    // Issue one command; call and return at #1 after a clock edge.
    task automatic issue(input bit wr, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input int awd, input int wd, input int bd,
                         input int ard, input int rd, input bit stl, input bit track);
        exp_t e;
        int n, lat;
        aw_dly = awd; w_dly = wd; b_dly = bd; ar_dly = ard; r_dly = rd; stall = stl;
        x_addr = a; x_wdata = d; x_wstrb = s;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        if (n == 50) begin
            check("accept_wait", 32'(cmd_ready), 1);
            cmd_valid = 1'b0;
            return;
        end
        lat = wr ? 3 + ((awd > wd) ? awd : wd) + bd : 3 + ard + rd;
        e.c0 = cyc; e.lat = lat; e.tmo = 1'b0; e.resp = a[5:4]; e.rdata = '0;
        if (stl || lat > TMO + 1) begin
            e.tmo = 1'b1; e.resp = 2'b11; e.lat = TMO + 1;
        end else if (track) begin
            if (wr) rmem[a] = merge(rmem.exists(a) ? rmem[a] : 32'h0, d, s);
            else e.rdata = rmem.exists(a) ? rmem[a] : 32'h0;
        end
        if (track) sb.push_back(e);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom); cmd_addr = $urandom; cmd_wdata = $urandom; cmd_wstrb = 4'($urandom);
        if (wr) check("c1_aw_w_valid", 32'({awvalid, wvalid}), 32'd3);
        else    check("c1_arvalid", 32'(arvalid), 1);
        if (track) begin
            n = 0;
            while (cmd_ready !== 1'b1 && n < 60) begin @(posedge clk); #1; n++; end
            if (n == 60) check("done_wait", 32'(cmd_ready), 1);
        end
    endtask

    initial begin
        int n;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
        {aw_dly, w_dly, b_dly, ar_dly, r_dly} = '0; stall = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready", 32'(cmd_ready), 0);
        check("rst_valids", 32'({awvalid, wvalid, bready, arvalid, rready}), 0);
        check("rst_rsp", 32'({rsp_valid, rsp_timeout, rsp_resp}), 0);
        check("rst_rdata", rsp_rdata, 0);
        check("rst_addr", awaddr, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("cmd_ready_after_rst", 32'(cmd_ready), 1);

        // Directed cases.
        issue(1, 32'h104, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, 0, 1);
        issue(1, 32'h120, 32'hCAFEF00D, 4'hF, 0, 4, 0, 0, 0, 0, 1);
        issue(1, 32'h200, 32'h12345678, 4'hF, 0, 0, 0, 0, 0, 0, 1);
        issue(0, 32'h200, 32'h0, 4'h0, 0, 0, 0, 3, 0, 0, 1);
        issue(0, 32'h204, 32'h0, 4'h0, 0, 0, 0, 0, 0, 1, 1);
        issue(0, 32'h104, 32'h0, 4'h0, 0, 0, 0, 0, 0, 0, 1);
        issue(1, 32'h108, 32'hA5A5A5A5, 4'hF, 0, 0, 6, 0, 0, 0, 1);
        issue(1, 32'h10C, 32'h5A5A5A5A, 4'hF, 0, 0, 7, 0, 0, 0, 1);
        issue(0, 32'h10C, 32'h0, 4'h0, 0, 0, 0, 0, 0, 0, 1);
        issue(1, 32'h104, 32'h11223344, 4'h5, 1, 2, 1, 0, 0, 0, 1);
        issue(0, 32'h104, 32'h0, 4'h0, 0, 0, 0, 1, 2, 0, 1);

        // Reset while the write waits in WR_B; the command is dropped.
        issue(1, 32'h108, 32'h99999999, 4'hF, 0, 0, 5, 0, 0, 0, 0);
        n = 0;
        while (bready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        check("reached_wr_b", 32'(bready), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valids", 32'({awvalid, wvalid, bready}), 0);
        check("async_rst_cmd_ready", 32'(cmd_ready), 0);
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;
        check("cmd_ready_after_rst2", 32'(cmd_ready), 1);
        issue(0, 32'h108, 32'h0, 4'h0, 0, 0, 0, 0, 0, 0, 1);

        // Random commands.
        for (int i = 0; i < 150; i++) begin
            issue(1'($urandom), 32'h100 + 32'($urandom_range(0, 15)) * 4, $urandom,
                  4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 2),
                  ($urandom_range(0, 9) == 0), 1);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end

        n = 0;
        while (sb.size() != 0 && n < 20) begin @(posedge clk); #1; n++; end
        check("scoreboard_drained", 32'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
